reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent active-low reset output channels, legal range 1..8.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles all channels stay asserted after any reset event, legal range 2..65535.
REQ-003 Parameter STAGGER, default 4: cycles between successive channel releases, legal range 1..255.
REQ-004 Parameter DEBOUNCE, default 1024: consecutive high cycles required on synchronised ext_rst_req, legal range 1..65535.
REQ-005 Port clk, input, 1: single clock, 48 MHz internal oscillator domain.
REQ-006 Port rst, input, 1: synchronous active-high reset; the block has one clock and this is its only reset.
REQ-007 Port ext_rst_req, input, 1: asynchronous active-high button or pin request.
REQ-008 Port sw_rst_req, input, 1: synchronous one-cycle active-high request from user logic.
REQ-009 Port rst_n_out, output, NUM_CH: per-channel active-low reset, suitable for driving RST_N of generated cores.
REQ-010 Port ready, output, 1: high once all channels are released.
REQ-011 Port rst_cause, output, 2: cause of the most recent reset event.

Function
REQ-012 FSM states: HOLD, RELEASE, RUN.
REQ-013 HOLD: rst_n_out all 0, ready 0, hold counter increments each cycle; counter reaching HOLD_CYCLES moves to RELEASE on that edge.
REQ-014 Channel 0 deasserts (rst_n_out[0]=1) on the edge that enters RELEASE.
REQ-015 RELEASE: stagger counter counts; channel k deasserts exactly STAGGER cycles after channel k-1; released channels stay released.
REQ-016 ready rises on the same edge as rst_n_out[NUM_CH-1]; the FSM moves to RUN on that edge; with NUM_CH=1 ready rises with channel 0.
REQ-017 Timing from first edge with rst=0 (edge 1): channel k rises after edge HOLD_CYCLES + k*STAGGER; defaults: 16, 20, 24, 28; ready after edge 28.
REQ-018 ext_rst_req passes through a 2-flop synchroniser; the debounce counter increments while synchronised value is 1, clears to 0 when it is 0.
REQ-019 Debounced request fires one pulse when the debounce counter reaches DEBOUNCE; no further pulse until synchronised input returns to 0.
REQ-020 A request (debounced ext pulse or sw_rst_req) in any state: next edge enters HOLD, all rst_n_out 0, ready 0, hold and stagger counters 0.
REQ-021 A request during HOLD or RELEASE restarts the full sequence; no partial release is permitted.
REQ-022 rst_cause updates on each event: 00 power-on/rst, 01 external, 10 software, 11 external and software in the same cycle.
REQ-023 rst_cause holds its value until the next event.
REQ-024 Counter widths are sized from parameters (clog2 of max value + 1); counters saturate and never wrap.
REQ-025 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-026 rst=1 at a clock edge forces: state HOLD, all counters 0, synchroniser flops 0, rst_n_out all 0, ready 0, rst_cause 00.
REQ-027 Every register has an initial value equal to its reset value, so the power-on sequence runs correctly with rst tied to 0.
REQ-028 rst asserted mid-sequence or in RUN takes effect on the next edge and overrides any simultaneous request; rst_cause becomes 00.
REQ-029 rst held high keeps the block in HOLD with the hold counter at 0.

Verification
REQ-030 Defaults, rst high 3 cycles then low -> rst_n_out goes 0001 after edge 16, 0011 after 20, 0111 after 24, 1111 and ready=1 after 28; rst_cause=00.
REQ-031 In RUN, ext_rst_req high for 1023 cycles then low -> no event; high for 1026 cycles -> event 2 sync cycles + 1024 cycles after rise, outputs 0000, rst_cause=01; a single event only.
REQ-032 sw_rst_req pulse during RELEASE after channel 1 is released -> next edge rst_n_out=0000; full 28-cycle sequence restarts; rst_cause=10.
REQ-033 sw_rst_req and debounced ext pulse on the same cycle -> rst_cause=11, one restart.
REQ-034 rst=1 on the same edge as sw_rst_req in RUN -> rst_cause=00; sequence restarts from edge 1 after rst falls.
REQ-035 NUM_CH=1, HOLD_CYCLES=2, STAGGER=1 -> rst_n_out[0] and ready rise together after edge 2.

Source files
------------

// File: rtl/reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reset_sequencer: holds all reset channels, then releases them one by one.
// Rev 1.0
// ----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int DEBOUNCE    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_rst_req,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              ready,
  output logic [1:0]        rst_cause
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int STG_W  = $clog2(STAGGER + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [1:0]        state     = ST_HOLD;
  logic [1:0]        state_nxt;
  logic              sync_meta = 1'b0;
  logic              sync_out  = 1'b0;
  logic [DEB_W-1:0]  deb_cnt   = '0;
  logic [HOLD_W-1:0] hold_cnt  = '0;
  logic [STG_W-1:0]  stg_cnt   = '0;
  logic [NUM_CH-1:0] rel_mask  = '0;
  logic              ready_reg = 1'b0;
  logic [1:0]        cause_reg = 2'b00;

  logic [HOLD_W-1:0] hold_nxt;
  logic [STG_W-1:0]  stg_nxt;
  logic [NUM_CH-1:0] mask_nxt;
  logic              ready_nxt;
  logic [1:0]        cause_nxt;
  logic [NUM_CH-1:0] rel_shift;
  logic              ext_pulse;
  logic              req;

  // Counter saturates at DEBOUNCE, so the match below fires once per high phase.
  assign ext_pulse = sync_out && (deb_cnt == DEB_LAST);
  assign req       = ext_pulse | sw_rst_req;
  assign rel_shift = (rel_mask << 1) | NUM_CH'(1);

  assign rst_n_out = rel_mask;
  assign ready     = ready_reg;
  assign rst_cause = cause_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync_meta <= ext_rst_req;
      sync_out  <= sync_meta;
      if (!sync_out)
        deb_cnt <= '0;
      else if (deb_cnt != DEB_MAX)
        deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      stg_cnt   <= '0;
      rel_mask  <= '0;
      ready_reg <= 1'b0;
      cause_reg <= 2'b00;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      stg_cnt   <= stg_nxt;
      rel_mask  <= mask_nxt;
      ready_reg <= ready_nxt;
      cause_reg <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD:
        if (hold_cnt == HOLD_LAST)
          state_nxt = rel_shift[NUM_CH-1] ? ST_RUN : ST_RELEASE;
      ST_RELEASE:
        if ((stg_cnt == STG_LAST) && rel_shift[NUM_CH-1])
          state_nxt = ST_RUN;
      ST_RUN:
        state_nxt = ST_RUN;
      default:
        state_nxt = ST_HOLD;
    endcase
    if (req)
      state_nxt = ST_HOLD;
  end

  always_comb begin
    hold_nxt  = hold_cnt;
    stg_nxt   = stg_cnt;
    mask_nxt  = rel_mask;
    ready_nxt = ready_reg;
    cause_nxt = cause_reg;
    case (state)
      ST_HOLD: begin
        mask_nxt  = '0;
        ready_nxt = 1'b0;
        if (hold_cnt == HOLD_LAST) begin
          hold_nxt  = HOLD_MAX;
          stg_nxt   = '0;
          mask_nxt  = rel_shift;
          ready_nxt = rel_shift[NUM_CH-1];
        end else if (hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (stg_cnt == STG_LAST) begin
          stg_nxt   = '0;
          mask_nxt  = rel_shift;
          ready_nxt = rel_shift[NUM_CH-1];
        end else begin
          stg_nxt = stg_cnt + 1'b1;
        end
      end
      default: ;
    endcase
    // Any request aborts whatever release is in progress.
    if (req) begin
      hold_nxt  = '0;
      stg_nxt   = '0;
      mask_nxt  = '0;
      ready_nxt = 1'b0;
      cause_nxt = {sw_rst_req, ext_pulse};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reset_sequencer: scoreboard bench for two parameterisations of the
// sequencer. Rev 1.0
// ----------------------------------------------------------------------------
module tb_reset_sequencer;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       ext  = 1'b0;
  logic       sw   = 1'b0;
  logic       ext2 = 1'b0;
  logic       sw2  = 1'b0;
  logic [3:0] rn0;
  logic       rdy0;
  logic [1:0] cause0;
  logic [0:0] rn1;
  logic       rdy1;
  logic [1:0] cause1;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_CH(4), .HOLD_CYCLES(16), .STAGGER(4), .DEBOUNCE(1024)) dut0 (
    .clk(clk), .rst(rst), .ext_rst_req(ext), .sw_rst_req(sw),
    .rst_n_out(rn0), .ready(rdy0), .rst_cause(cause0)
  );

  reset_sequencer #(.NUM_CH(1), .HOLD_CYCLES(2), .STAGGER(1), .DEBOUNCE(4)) dut1 (
    .clk(clk), .rst(rst), .ext_rst_req(ext2), .sw_rst_req(sw2),
    .rst_n_out(rn1), .ready(rdy1), .rst_cause(cause1)
  );

  typedef struct {
    int         id;
    int         at;
    logic [7:0] mask;
    logic       rdy;
    logic [1:0] cause;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id, input int at, input logic [7:0] m,
                      input logic r, input logic [1:0] c);
    exp_t e;
    if (at > cyc) begin
      e.id = id; e.at = at; e.mask = m; e.rdy = r; e.cause = c;
      sb.push_back(e);
    end
  endtask

  // Expected outputs of a full hold/release sequence whose HOLD entry is edge e.
  task automatic push_seq(input int id, input int e, input logic [1:0] c);
    int n, h, s, t;
    n = (id == 0) ? 4 : 1;
    h = (id == 0) ? 16 : 2;
    s = (id == 0) ? 4 : 1;
    push(id, e, 8'h00, 1'b0, c);
    for (int k = 0; k < n; k++) begin
      t = e + h + k * s;
      push(id, t - 1, 8'((1 << k) - 1), 1'b0, c);
      push(id, t, 8'((1 << (k + 1)) - 1), (k == n - 1), c);
    end
  endtask

  task automatic push_event(input int id, input int e, input logic [7:0] pm,
                            input logic pr, input logic [1:0] pc, input logic [1:0] c);
    push(id, e - 1, pm, pr, pc);
    push_seq(id, e, c);
  endtask

  task automatic tick();
    int i;
    logic [7:0] m;
    logic       r;
    logic [1:0] c;
    @(posedge clk);
    #1;
    cyc++;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at <= cyc) begin
        m = (sb[i].id == 0) ? {4'b0, rn0} : {7'b0, rn1};
        r = (sb[i].id == 0) ? rdy0 : rdy1;
        c = (sb[i].id == 0) ? cause0 : cause1;
        check($sformatf("d%0d_at%0d_cyc", sb[i].id, sb[i].at), cyc, sb[i].at);
        check($sformatf("d%0d_mask@%0d", sb[i].id, cyc), {24'b0, m}, {24'b0, sb[i].mask});
        check($sformatf("d%0d_ready@%0d", sb[i].id, cyc), {31'b0, r}, {31'b0, sb[i].rdy});
        check($sformatf("d%0d_cause@%0d", sb[i].id, cyc), {30'b0, c}, {30'b0, sb[i].cause});
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // Reset held for three edges, then power-on sequence from edge 1.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_mask", {28'b0, rn0}, 32'h0);
      check("rst_ready", {31'b0, rdy0}, 32'h0);
      check("rst_cause", {30'b0, cause0}, 32'h0);
      check("rst_d1", {30'b0, rn1, rdy1}, 32'h0);
    end
    cyc = 0;
    rst = 1'b0;
    push_seq(0, 0, 2'b00);
    push_seq(1, 0, 2'b00);
    run(30);
    check("por_done", {25'b0, rn0, rdy0, cause0}, {25'b0, 4'hF, 1'b1, 2'b00});
    check("sb_empty_por", sb.size(), 0);

    // Short debounce on the single-channel instance.
    cur  = cyc;
    ext2 = 1'b1;
    push_event(1, cur + 6, 8'h01, 1'b1, 2'b00, 2'b01);
    run(6);
    ext2 = 1'b0;
    run(10);
    check("d1_ext_done", {28'b0, rn1, rdy1, cause1}, {28'b0, 1'b1, 1'b1, 2'b01});

    // External request one cycle too short: no event.
    ext = 1'b1;
    run(1023);
    ext = 1'b0;
    run(1100);
    check("ext_short", {25'b0, rn0, rdy0, cause0}, {25'b0, 4'hF, 1'b1, 2'b00});

    // Long enough external request: single event.
    cur = cyc;
    ext = 1'b1;
    push_event(0, cur + 1026, 8'h0F, 1'b1, 2'b00, 2'b01);
    run(1026);
    ext = 1'b0;
    run(40);
    check("ext_done", {25'b0, rn0, rdy0, cause0}, {25'b0, 4'hF, 1'b1, 2'b01});
    check("sb_empty_ext", sb.size(), 0);

    // Software request, then another during RELEASE after channel 1.
    cur = cyc;
    sw  = 1'b1;
    push_event(0, cur + 1, 8'h0F, 1'b1, 2'b01, 2'b10);
    run(1);
    sw = 1'b0;
    run(22);
    check("sw_mid_mask", {28'b0, rn0}, 32'h3);
    cur = cyc;
    sw  = 1'b1;
    sb.delete();
    push_event(0, cur + 1, 8'h03, 1'b0, 2'b10, 2'b10);
    run(1);
    sw = 1'b0;
    run(32);
    check("sw_done", {25'b0, rn0, rdy0, cause0}, {25'b0, 4'hF, 1'b1, 2'b10});
    check("sb_empty_sw", sb.size(), 0);

    // Software and debounced external on the same edge.
    cur = cyc;
    ext = 1'b1;
    push_event(0, cur + 1026, 8'h0F, 1'b1, 2'b10, 2'b11);
    run(1025);
    sw = 1'b1;
    run(1);
    sw  = 1'b0;
    ext = 1'b0;
    run(40);
    check("both_done", {25'b0, rn0, rdy0, cause0}, {25'b0, 4'hF, 1'b1, 2'b11});
    check("sb_empty_both", sb.size(), 0);

    // rst overrides a simultaneous software request.
    cur = cyc;
    rst = 1'b1;
    sw  = 1'b1;
    push(0, cur + 1, 8'h00, 1'b0, 2'b00);
    push(1, cur + 1, 8'h00, 1'b0, 2'b00);
    run(1);
    sw = 1'b0;
    run(2);
    check("rst_hold_mask", {28'b0, rn0}, 32'h0);
    rst = 1'b0;
    push_seq(0, cyc, 2'b00);
    push_seq(1, cyc, 2'b00);
    run(32);
    check("rst_sw_done", {25'b0, rn0, rdy0, cause0}, {25'b0, 4'hF, 1'b1, 2'b00});
    check("sb_empty_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
